// File: rtl/key_conditioner.sv
// Synchroniser, per-key debouncer and press strobes for the DE1-SoC KEY[3:0] inputs.
// Define KEY_AUTOREPEAT_EN to add hold-to-repeat on left/right (bits 1:0).
module key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_raw,
   output logic       key_right,
   output logic       key_left,
   output logic       key_select,
   output logic       key_back,
   output logic [3:0] press_pulse
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
       longint'(DEBOUNCE_CYCLES) - 1 >= (longint'(1) << CNT_W)) begin : g_bad_cfg
      $error("key_conditioner: invalid DEBOUNCE/REPEAT/CNT_W parameters");
   end

   logic [3:0]       sync1_q, sync2_q;
   logic [3:0]       deb_q, deb_nxt, fall;
   logic [3:0]       key_lvl, pulse_nxt, pulse_q;
   logic [CNT_W-1:0] cnt_q   [4];
   logic [CNT_W-1:0] cnt_nxt [4];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
      end
   end

   // Any cycle where sync agrees with deb restarts the qualification window.
   always_comb begin
      deb_nxt = deb_q;
      for (int i = 0; i < 4; i++) begin
         cnt_nxt[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DEB_LAST) deb_nxt[i] = sync2_q[i];
            else                      cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_q <= '1;
         cnt_q <= '{default: '0};
      end else begin
         deb_q <= deb_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   assign fall = deb_q & ~deb_nxt;

`ifdef KEY_AUTOREPEAT_EN
   // state  | meaning
   // IDLE   | key released (or awaiting debounced press)
   // DELAY  | held, counting REPEAT_DELAY before the first repeat
   // GAP    | one-cycle high so downstream sees a new falling edge
   // REPEAT | held low again, counting REPEAT_PERIOD to the next gap
   typedef enum logic [1:0] {IDLE, DELAY, GAP, REPEAT} rep_state_t;

   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

   if (longint'(REPEAT_DELAY) - 1 >= (longint'(1) << CNT_W) ||
       longint'(REPEAT_PERIOD) - 1 >= (longint'(1) << CNT_W)) begin : g_bad_rep_cfg
      $error("key_conditioner: CNT_W too small for repeat timing");
   end

   rep_state_t       rep_q    [2];
   rep_state_t       rep_nxt  [2];
   logic [CNT_W-1:0] rcnt_q   [2];
   logic [CNT_W-1:0] rcnt_nxt [2];
   logic [1:0]       rep_lvl_q, rep_lvl_nxt, rep_pulse;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_q     <= '{default: IDLE};
         rcnt_q    <= '{default: '0};
         rep_lvl_q <= '1;
      end else begin
         rep_q     <= rep_nxt;
         rcnt_q    <= rcnt_nxt;
         rep_lvl_q <= rep_lvl_nxt;
      end
   end

   always_comb begin
      rep_lvl_nxt = rep_lvl_q;
      rep_pulse   = '0;
      for (int j = 0; j < 2; j++) begin
         rep_nxt[j]  = rep_q[j];
         rcnt_nxt[j] = rcnt_q[j];
         if (deb_nxt[j]) begin
            rep_nxt[j]     = IDLE;
            rcnt_nxt[j]    = '0;
            rep_lvl_nxt[j] = 1'b1;
         end else begin
            case (rep_q[j])
               IDLE: if (fall[j]) begin
                  rep_nxt[j]     = DELAY;
                  rcnt_nxt[j]    = '0;
                  rep_lvl_nxt[j] = 1'b0;
                  rep_pulse[j]   = 1'b1;
               end
               DELAY: if (rcnt_q[j] == DLY_LAST) begin
                  rep_nxt[j]     = GAP;
                  rcnt_nxt[j]    = '0;
                  rep_lvl_nxt[j] = 1'b1;
               end else begin
                  rcnt_nxt[j] = rcnt_q[j] + CNT_W'(1);
               end
               GAP: begin
                  rep_nxt[j]     = REPEAT;
                  rcnt_nxt[j]    = '0;
                  rep_lvl_nxt[j] = 1'b0;
                  rep_pulse[j]   = 1'b1;
               end
               REPEAT: if (rcnt_q[j] == PER_LAST) begin
                  rep_nxt[j]     = GAP;
                  rcnt_nxt[j]    = '0;
                  rep_lvl_nxt[j] = 1'b1;
               end else begin
                  rcnt_nxt[j] = rcnt_q[j] + CNT_W'(1);
               end
               default: rep_nxt[j] = IDLE;
            endcase
         end
      end
   end

   assign key_lvl   = {deb_q[3:2], rep_lvl_q};
   assign pulse_nxt = {fall[3:2], rep_pulse};
`else
   assign key_lvl   = deb_q;
   assign pulse_nxt = fall;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pulse_q <= '0;
      else      pulse_q <= pulse_nxt;
   end

   assign key_right   = key_lvl[0];
   assign key_left    = key_lvl[1];
   assign key_select  = key_lvl[2];
   assign key_back    = key_lvl[3];
   assign press_pulse = pulse_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: window-based reference model, randomized bounce traffic.
module tb_key_conditioner;
   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] key_raw = 4'hF;
   logic       key_right, key_left, key_select, key_back;
   logic [3:0] press_pulse;

   key_conditioner #(
      .DEBOUNCE_CYCLES(DEB), .CNT_W(8), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .rst(rst), .key_raw(key_raw),
      .key_right(key_right), .key_left(key_left),
      .key_select(key_select), .key_back(key_back),
      .press_pulse(press_pulse)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] keys;
      logic [3:0] pulse;
   } exp_t;

   exp_t       exp_q[$];
   int         tests = 0;
   int         fails = 0;
   int         edge_n = 0;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s @edge %0d: got %b expected %b", name, edge_n, act, want);
      end
   endtask

   // Reference model: sampled raw history per clock edge. A key's debounced
   // level flips when the raw samples taken 2..5 edges ago all disagree with it.
   logic [3:0] hist[$];
   logic [3:0] deb_m;
   int         hold[2];

   initial begin
      exp_t       e;
      logic [3:0] prev;
      bit         stable;
      int         p;
      for (int j = 0; j < 8; j++) hist.push_back(4'hF);
      deb_m = 4'hF;
      hold[0] = 0;
      hold[1] = 0;
      forever begin
         @(posedge clk);
         edge_n++;
         if (!rst) begin
            for (int j = 0; j < 8; j++) hist.push_back(4'hF);
            deb_m   = 4'hF;
            e.keys  = 4'hF;
            e.pulse = 4'h0;
         end else begin
            hist.push_back(key_raw);
            while (hist.size() > 8) void'(hist.pop_front());
            prev = deb_m;
            for (int i = 0; i < 4; i++) begin
               stable = 1'b1;
               for (int j = 2; j <= 5; j++)
                  if (hist[hist.size() - 1 - j][i] == deb_m[i]) stable = 1'b0;
               if (stable) deb_m[i] = ~deb_m[i];
            end
            e.keys  = deb_m;
            e.pulse = prev & ~deb_m;
`ifdef KEY_AUTOREPEAT_EN
            for (int i = 0; i < 2; i++) begin
               if (e.pulse[i]) hold[i] = 0;
               else if (!deb_m[i]) hold[i]++;
               if (!deb_m[i] && hold[i] >= RD) begin
                  p = (hold[i] - RD) % (RP + 1);
                  e.keys[i]  = (p == 0);
                  e.pulse[i] = (p == 1);
               end
            end
`endif
         end
         while (hist.size() > 8) void'(hist.pop_front());
         exp_q.push_back(e);
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty @edge %0d: got no entry expected one", edge_n);
         end else begin
            e = exp_q.pop_front();
            check("keys", {key_back, key_select, key_left, key_right}, e.keys);
            check("pulse", press_pulse, e.pulse);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic post(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int prob;
      logic exp16;
`ifdef KEY_AUTOREPEAT_EN
      exp16 = 1'b1;
`else
      exp16 = 1'b0;
`endif
      // reset behaviour, including raw activity while held in reset
      cyc(3);
      key_raw = 4'h0;
      cyc(4);
      check("hold_rst_keys", {key_back, key_select, key_left, key_right}, 4'hF);
      check("hold_rst_pulse", press_pulse, 4'h0);
      key_raw = 4'hF;
      cyc(2);
      rst = 1'b1;
      cyc(8);

      // clean press / release of select
      key_raw[2] = 1'b0;
      post(5);
      check("sel_before_fall", {3'b0, key_select}, 4'h1);
      post(1);
      check("sel_fall", {3'b0, key_select}, 4'h0);
      check("sel_pulse", press_pulse, 4'b0100);
      post(1);
      check("sel_pulse_len", press_pulse, 4'h0);
      cyc(6);
      key_raw[2] = 1'b1;
      post(5);
      check("sel_before_rise", {3'b0, key_select}, 4'h0);
      post(1);
      check("sel_rise", {3'b0, key_select}, 4'h1);
      check("sel_no_rel_pulse", press_pulse, 4'h0);
      cyc(6);

      // bounce on left
      key_raw[1] = 1'b0;
      cyc(3);
      key_raw[1] = 1'b1;
      cyc(1);
      key_raw[1] = 1'b0;
      cyc(12);
      key_raw = 4'hF;
      cyc(10);

      // right and back together
      key_raw = 4'b0110;
      cyc(12);
      key_raw = 4'hF;
      cyc(10);

      // long hold of right, then of select
      key_raw = 4'b1110;
      post(16);
      check("rpt_gap16", {3'b0, key_right}, {3'b0, exp16});
      post(1);
      check("rpt_fall17", {3'b0, key_right}, 4'h0);
      check("rpt_pulse17", press_pulse, {3'b0, exp16});
      cyc(23);
      key_raw = 4'hF;
      cyc(10);
      key_raw = 4'b1011;
      cyc(40);
      key_raw = 4'hF;
      cyc(10);

      // reset while back is held
      key_raw = 4'b0111;
      cyc(15);
      rst = 1'b0;
      #1;
      check("rst_back_immediate", {3'b0, key_back}, 4'h1);
      check("rst_pulse_immediate", press_pulse, 4'h0);
      cyc(3);
      rst = 1'b1;
      post(5);
      check("requal_before", {3'b0, key_back}, 4'h1);
      post(1);
      check("requal_fall", {3'b0, key_back}, 4'h0);
      check("requal_pulse", press_pulse, 4'b1000);
      cyc(5);
      key_raw = 4'hF;
      cyc(10);

      // randomized bouncing and holds
      for (int c = 0; c < 900; c++) begin
         case ((c / 60) % 3)
            0:       prob = 30;
            1:       prob = 4;
            default: prob = 1;
         endcase
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 99) < prob) key_raw[i] = ~key_raw[i];
         if ($urandom_range(0, 399) == 0) rst = 1'b0;
         else rst = 1'b1;
         cyc(1);
      end
      rst = 1'b1;
      key_raw = 4'hF;
      cyc(12);
      @(posedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
